// File: rtl/imem_load_ctrl_if.sv
// Loader, fetch and memory-side signal bundle for imem_load_ctrl.
// IMEM_LOAD_CHECKSUM_EN adds the load_csum signal.
interface imem_load_ctrl_if #(
  parameter int AW = 6
);
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_done;
  logic          ld_ready;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic          fetch_valid;
  logic          cpu_hold;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [AW:0]   load_count;
  logic          load_ovf;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]   load_csum;
`endif

  // master is the controller; slave is the loader/CPU/memory environment.
  modport master (
    input  ld_start, ld_valid, ld_byte, ld_done, fetch_req, fetch_addr, mem_rdata,
    output ld_ready, fetch_data, fetch_valid, cpu_hold, mem_addr, mem_we, mem_wdata,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output load_csum,
`endif
    output load_count, load_ovf
  );

  modport slave (
    output ld_start, ld_valid, ld_byte, ld_done, fetch_req, fetch_addr, mem_rdata,
    input  ld_ready, fetch_data, fetch_valid, cpu_hold, mem_addr, mem_we, mem_wdata,
`ifdef IMEM_LOAD_CHECKSUM_EN
    input  load_csum,
`endif
    input  load_count, load_ovf
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Byte-stream instruction memory loader with CPU fetch path and CPU hold.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds an XOR checksum of written words.
module imem_load_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  imem_load_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t      state, next_state;
  logic [1:0]  idx;
  logic [31:0] word;
  logic [AW:0] count;
  logic        ovf;
  logic        fvalid;
  logic        full;
  logic        accept;

  // count doubles as the write pointer; its top bit means the memory is full.
  assign full   = count[AW];
  assign accept = (state == LOAD) && bus.ld_valid && !bus.ld_start && !bus.ld_done;

  wire unused_addr_bits = &{1'b0, bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state    = state;
    bus.ld_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_hold  = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.ld_start)     next_state = LOAD;
        else if (bus.ld_done) next_state = RUN;
      end
      LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_start)                  next_state = LOAD;
        else if (bus.ld_done)              next_state = RUN;
        else if (accept && idx == 2'd3)    next_state = WRITE;
      end
      WRITE: begin
        // Reset in this cycle must not let the write through.
        bus.mem_we    = !full && !reset;
        bus.mem_addr  = count[AW-1:0];
        bus.mem_wdata = word;
        if (bus.ld_start)     next_state = LOAD;
        else if (bus.ld_done) next_state = RUN;
        else                  next_state = LOAD;
      end
      RUN: begin
        bus.cpu_hold = 1'b0;
        bus.mem_addr = bus.fetch_addr[AW+1:2];
        if (bus.ld_start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] csum;
  assign bus.load_csum = csum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      word   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      fvalid <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      fvalid <= (state == RUN) && bus.fetch_req;
      if (bus.ld_start) begin
        // A pending write in WRITE still happens this cycle; only the
        // session bookkeeping restarts.
        idx   <= '0;
        count <= '0;
        ovf   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum  <= '0;
`endif
      end else begin
        unique case (state)
          LOAD: begin
            if (bus.ld_done) begin
              idx <= '0;
            end else if (accept) begin
              word[8*idx +: 8] <= bus.ld_byte;
              idx              <= idx + 2'd1;
            end
          end
          WRITE: begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              count <= count + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
              csum  <= csum ^ word;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.load_count  = count;
  assign bus.load_ovf    = ovf;
  assign bus.fetch_valid = fvalid;
  assign bus.fetch_data  = fvalid ? bus.mem_rdata : 32'h0;

endmodule
